// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI master transmitter.
package spi_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } state_t;

endpackage

// File: rtl/spi_master_tx_if.sv
// Word-level request/response port between local command logic and the SPI master.
interface spi_master_tx_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);

    // A word is accepted on the clk edge where tx_valid and tx_ready are both high;
    // tx_data is only sampled on that edge. rx_valid is a one-cycle pulse with rx_data
    // already valid, and there is no back-pressure on the receive side.
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

endinterface

// File: rtl/spi_half_period_timer.sv
// Down-counter that ticks once every CLK_DIV enabled cycles; a load restarts the period.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
        end
    end

    assign tick = en && !load && (cnt == '0);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: sends one DATA_W word MSB first per frame and returns the MISO word.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_master_tx_if.slave        bus,
    output logic                  busy,
    output logic                  SLK,
    output logic                  MOSI,
    output logic                  CS,
    input  logic                  MISO,
    output state_t                state
);

    localparam int            BW       = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [BW-1:0]     bit_cnt;
    logic              accept;
    logic              timer_en;
    logic              tick;

    assign accept   = bus.tx_valid && bus.tx_ready;
    assign timer_en = (state != IDLE);

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (timer_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            bus.tx_ready <= 1'b1;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            busy         <= 1'b0;
            SLK          <= 1'b0;
            MOSI         <= 1'b0;
            CS           <= 1'b1;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift     <= bus.tx_data;
                        bit_cnt      <= LAST_BIT;
                        MOSI         <= bus.tx_data[DATA_W-1];
                        CS           <= 1'b0;
                        SLK          <= 1'b0;
                        bus.tx_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= LEAD;
                    end
                end
                LEAD, LOW: begin
                    // MISO is launched by the slave off our SLK, so it is stable here.
                    if (tick) begin
                        SLK      <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], MISO};
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        SLK <= 1'b0;
                        if (bit_cnt == '0) begin
                            state <= TRAIL;
                        end else begin
                            bit_cnt  <= bit_cnt - 1'b1;
                            tx_shift <= tx_shift << 1;
                            MOSI     <= tx_shift[DATA_W-2];
                            state    <= LOW;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        CS           <= 1'b1;
                        MOSI         <= 1'b0;
                        bus.rx_data  <= rx_shift;
                        bus.rx_valid <= 1'b1;
                        state        <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        bus.tx_ready <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: vector table, random frames against a frame-level model, corner sequences.
module tb_spi_master_tx;
    import spi_pkg::*;

    localparam int DW   = 8;
    localparam int DIV  = 4;
    localparam int DIV2 = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (defaults) ----------------
    spi_master_tx_if #(.DATA_W(DW)) bus ();
    logic   busy, SLK, MOSI, CS, MISO;
    state_t state;

    spi_master_tx #(.DATA_W(DW), .CLK_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy),
        .SLK   (SLK),
        .MOSI  (MOSI),
        .CS    (CS),
        .MISO  (MISO),
        .state (state)
    );

    // ---------------- DUT (fast divider, loopback) ----------------
    spi_master_tx_if #(.DATA_W(DW)) bus2 ();
    logic   busy2, slk2, mosi2, cs2, miso2;
    state_t state2;
    assign miso2 = mosi2;

    spi_master_tx #(.DATA_W(DW), .CLK_DIV(DIV2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave),
        .busy  (busy2),
        .SLK   (slk2),
        .MOSI  (mosi2),
        .CS    (cs2),
        .MISO  (miso2),
        .state (state2)
    );

    // ---------------- slave model: 0 loopback, 1 tied high, 2 pattern ----------------
    int         miso_mode = 0;
    logic [7:0] miso_pat  = 8'h00;
    logic [3:0] rise_idx  = 4'd0;

    always_comb begin
        MISO = MOSI;
        if (miso_mode == 1) MISO = 1'b1;
        else if (miso_mode == 2) MISO = miso_pat[3'd7 - rise_idx[2:0]];
    end

    // ---------------- monitor ----------------
    logic       prev_slk = 1'b0;
    logic       prev_cs  = 1'b1;
    logic       prev_rdy = 1'b1;
    int         rise_q[$], fall_q[$], cs_fall_q[$], cs_rise_q[$], rdy_q[$], rxv_q[$], slk_err_q[$];
    logic       mosi_q[$];
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        prev_slk <= SLK;
        prev_cs  <= CS;
        prev_rdy <= bus.tx_ready;
        if (SLK && !prev_slk) begin
            rise_q.push_back(cyc);
            mosi_q.push_back(MOSI);
            rise_idx <= rise_idx + 4'd1;
            if (CS) slk_err_q.push_back(cyc);
        end
        if (!SLK && prev_slk) begin
            fall_q.push_back(cyc);
            if (CS) slk_err_q.push_back(cyc);
        end
        if (!CS && prev_cs) begin
            cs_fall_q.push_back(cyc);
            rise_idx <= 4'd0;
        end
        if (CS && !prev_cs) cs_rise_q.push_back(cyc);
        if (bus.tx_ready && !prev_rdy) rdy_q.push_back(cyc);
        if (bus.rx_valid) begin
            rxv_q.push_back(cyc);
            got_q.push_back(bus.rx_data);
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic score();
        while (got_q.size() > 0) begin
            logic [7:0] g;
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h expected no word", g);
            end else begin
                chk("rx_data", g, exp_q.pop_front());
            end
        end
    endtask

    // Reference: what the master must return given the slave behaviour.
    function automatic logic [7:0] model_rx(input int mode, input logic [7:0] w, input logic [7:0] pat);
        if (mode == 0) return w;
        if (mode == 1) return 8'hFF;
        return pat;
    endfunction

    // Reference waveform {CS, SLK, tx_ready, rx_valid, busy} at cycle t after the accept cycle.
    function automatic logic [4:0] model_wave(input int div, input int t);
        logic cs, slk, rdy, rxv, bsy;
        int   cs_hi, rdy_t;
        cs_hi = 1 + div * (2 * DW + 1);
        rdy_t = 1 + div * (2 * DW + 2);
        cs    = !(t >= 1 && t < cs_hi);
        slk   = 1'b0;
        for (int k = 0; k < DW; k++)
            if (t >= 1 + div * (1 + 2 * k) && t < 1 + div * (2 + 2 * k)) slk = 1'b1;
        rdy = (t >= rdy_t);
        rxv = (t == cs_hi);
        bsy = (t >= 1 && t < rdy_t);
        return {cs, slk, rdy, rxv, bsy};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear();
        rise_q.delete(); fall_q.delete(); cs_fall_q.delete(); cs_rise_q.delete();
        rdy_q.delete(); rxv_q.delete(); slk_err_q.delete(); mosi_q.delete(); got_q.delete();
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (!bus.tx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.tx_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: tx_ready %0b expected 1", bus.tx_ready);
        end
    endtask

    task automatic start(input logic [7:0] w, output int t0);
        wait_idle();
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        t0           = cyc;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic wait_ready(input int n);
        int k = 0;
        while (rdy_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (rdy_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: ready events %0d expected %0d", rdy_q.size(), n);
        end
    endtask

    task automatic check_frame(input int t0, input logic [7:0] w);
        logic [7:0] sent = '0;
        int         bad  = 0;
        foreach (mosi_q[i]) sent = {sent[6:0], mosi_q[i]};
        chk("slk_rises", mosi_q.size(), DW);
        chk("mosi_bits", sent, w);
        chk("cs_fall_at", cs_fall_q[0] - t0, 1);
        chk("first_rise_at", rise_q[0] - t0, 1 + DIV);
        chk("cs_rise_at", cs_rise_q[0] - t0, 1 + DIV * (2 * DW + 1));
        chk("cs_low_len", cs_rise_q[0] - cs_fall_q[0], DIV * (2 * DW + 1));
        chk("rx_valid_count", rxv_q.size(), 1);
        chk("rx_valid_at", rxv_q[0] - t0, 1 + DIV * (2 * DW + 1));
        chk("ready_back_at", rdy_q[0] - t0, 1 + DIV * (2 * DW + 2));
        for (int k = 0; k < rise_q.size(); k++) begin
            if (fall_q[k] - rise_q[k] != DIV) bad++;
            if (k + 1 < rise_q.size() && rise_q[k+1] - fall_q[k] != DIV) bad++;
        end
        chk("slk_pulse_widths_bad", bad, 0);
        chk("slk_edge_cs_high", slk_err_q.size(), 0);
    endtask

    task automatic run_frame(input logic [7:0] w, input int mode, input logic [7:0] pat, input logic [7:0] exp);
        int t0;
        clear();
        miso_mode = mode;
        miso_pat  = pat;
        start(w, t0);
        exp_q.push_back(exp);
        wait_ready(1);
        check_frame(t0, w);
        score();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] tx;
        int         mode;
        logic [7:0] pat;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int         t0, t0b, k;
        logic [7:0] w, pat;
        int         mode;
        logic [15:0] sent16;

        vecs[0] = '{8'hA5, 0, 8'h00, 8'hA5};
        vecs[1] = '{8'h00, 1, 8'h00, 8'hFF};
        vecs[2] = '{8'hC3, 2, 8'h5A, 8'h5A};
        vecs[3] = '{8'h7E, 2, 8'h81, 8'h81};

        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus2.tx_valid = 1'b0;
        bus2.tx_data  = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cs", CS, 1);
        chk("rst_slk", SLK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_state", state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_frame(vecs[i].tx, vecs[i].mode, vecs[i].pat, vecs[i].exp_rx);

        // busy rejection: a second request mid-frame must be ignored
        clear();
        miso_mode = 0;
        start(8'h3C, t0);
        exp_q.push_back(8'h3C);
        while (cyc < t0 + 10) @(negedge clk);
        chk("busy_mid_frame", busy, 1);
        chk("ready_mid_frame", bus.tx_ready, 0);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_ready(1);
        check_frame(t0, 8'h3C);
        repeat (8) @(negedge clk);
        chk("frames_started", cs_fall_q.size(), 1);
        score();

        // reset mid-frame: asynchronous return to reset values, word discarded
        clear();
        start(8'h5A, t0);
        while (cyc < t0 + 30) @(negedge clk);
        chk("slk_before_reset", SLK, 1);
        chk("cs_before_reset", CS, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cs", CS, 1);
        chk("async_rst_slk", SLK, 0);
        chk("async_rst_mosi", MOSI, 0);
        chk("async_rst_state", state, IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rx_after_abort", got_q.size(), 0);
        chk("ready_after_abort", bus.tx_ready, 1);
        run_frame(8'h81, 0, 8'h00, 8'h81);

        // back-to-back frames with tx_valid held high
        clear();
        miso_mode = 0;
        wait_idle();
        bus.tx_data  = 8'h12;
        bus.tx_valid = 1'b1;
        t0           = cyc;
        @(negedge clk);
        bus.tx_data = 8'h34;
        k = 0;
        while (!bus.tx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        t0b = cyc;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        wait_ready(2);
        sent16 = '0;
        foreach (mosi_q[i]) sent16 = {sent16[14:0], mosi_q[i]};
        chk("b2b_spacing", t0b - t0, 1 + DIV * (2 * DW + 2));
        chk("b2b_frames", cs_fall_q.size(), 2);
        chk("b2b_cs_gap", cs_fall_q[1] - cs_rise_q[0], DIV + 1);
        chk("b2b_mosi", sent16, 16'h1234);
        chk("b2b_rx_count", rxv_q.size(), 2);
        score();

        // random frames against the reference model
        for (int i = 0; i < 6; i++) begin
            w    = 8'($urandom_range(0, 255));
            pat  = 8'($urandom);
            mode = $urandom_range(0, 2);
            run_frame(w, mode, pat, model_rx(mode, w, pat));
        end

        // fast divider: cycle-by-cycle waveform against the timing formula
        @(negedge clk);
        chk("dut2_ready_idle", bus2.tx_ready, 1);
        bus2.tx_data  = 8'h6B;
        bus2.tx_valid = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (t == 1) bus2.tx_valid = 1'b0;
            chk($sformatf("dut2_wave_t%0d", t), {cs2, slk2, bus2.tx_ready, bus2.rx_valid, busy2},
                model_wave(DIV2, t));
        end
        chk("dut2_rx_data", bus2.rx_data, 8'h6B);
        chk("dut2_state", state2, IDLE);

        score();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
